// File: rtl/gpu_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gpu_mem_pkg
//  Description : Shared types and constants for the multi-channel memory
//                responder: per-channel FSM state, operation kind, default
//                widths and a saturating counter helper.
//  Revision    : 1.0  initial release
// ============================================================================
package gpu_mem_pkg;

    localparam int unsigned c_DEFAULT_ADDR_BITS    = 8;
    localparam int unsigned c_DEFAULT_DATA_BITS    = 8;
    localparam int unsigned c_DEFAULT_NUM_CHANNELS = 4;
    localparam int unsigned c_DEFAULT_LATENCY      = 2;
    localparam int unsigned c_LAT_CNT_BITS         = 4;   // holds LATENCY-2 for LATENCY <= 15
    localparam int unsigned c_COUNT_BITS           = 16;
    localparam int unsigned c_INC_BITS             = 8;   // per-cycle completion tally

    typedef enum logic [1:0] {
        CH_IDLE = 2'd0,
        CH_WAIT = 2'd1,
        CH_RESP = 2'd2
    } ch_state_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

    // Counter add that sticks at all-ones instead of wrapping.
    function automatic logic [c_COUNT_BITS-1:0] sat_add(
        input logic [c_COUNT_BITS-1:0] a,
        input logic [c_INC_BITS-1:0]   b
    );
        logic [c_COUNT_BITS:0] s;
        s = {1'b0, a} + {{(c_COUNT_BITS + 1 - c_INC_BITS){1'b0}}, b};
        return s[c_COUNT_BITS] ? {c_COUNT_BITS{1'b1}} : s[c_COUNT_BITS-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_resp_channel.sv
`default_nettype none
// ============================================================================
//  Module      : mem_resp_channel
//  Description : One request channel: IDLE/WAIT/RESP FSM with latency counter.
//                Exposes the request that is about to enter RESP so the parent
//                can perform the array access on that same edge.
//  Ports       : clk, reset (sync, active-low)
//                read_valid_i/read_addr_i           read request
//                write_valid_i/write_addr_i/_data_i write request
//                enter_o       request enters RESP at the coming edge
//                req_write_o/req_addr_o/req_data_o  request being entered
//                read_ready_o/write_ready_o         acknowledge while in RESP
//  Revision    : 1.0  initial release
// ============================================================================
module mem_resp_channel
    import gpu_mem_pkg::*;
#(
    parameter int ADDR_BITS = c_DEFAULT_ADDR_BITS,
    parameter int DATA_BITS = c_DEFAULT_DATA_BITS,
    parameter int LATENCY   = c_DEFAULT_LATENCY
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 read_valid_i,
    input  logic [ADDR_BITS-1:0] read_addr_i,
    input  logic                 write_valid_i,
    input  logic [ADDR_BITS-1:0] write_addr_i,
    input  logic [DATA_BITS-1:0] write_data_i,
    output logic                 enter_o,
    output logic                 req_write_o,
    output logic [ADDR_BITS-1:0] req_addr_o,
    output logic [DATA_BITS-1:0] req_data_o,
    output logic                 read_ready_o,
    output logic                 write_ready_o
);

    localparam logic [c_LAT_CNT_BITS-1:0] c_WAIT_INIT =
        (LATENCY > 1) ? c_LAT_CNT_BITS'(LATENCY - 2) : '0;

    ch_state_e                 state_q, state_d;
    op_e                       op_q, op_d;
    logic [ADDR_BITS-1:0]      addr_q, addr_d;
    logic [DATA_BITS-1:0]      data_q, data_d;
    logic [c_LAT_CNT_BITS-1:0] cnt_q, cnt_d;
    logic                      hold_w;

    // RESP is held only by the valid of the operation being answered.
    assign hold_w = (op_q == OP_READ) ? read_valid_i : write_valid_i;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        enter_o = 1'b0;
        case (state_q)
            CH_IDLE: begin
                if (read_valid_i) begin
                    op_d   = OP_READ;
                    addr_d = read_addr_i;
                end else if (write_valid_i) begin
                    op_d   = OP_WRITE;
                    addr_d = write_addr_i;
                    data_d = write_data_i;
                end
                if (read_valid_i || write_valid_i) begin
                    if (LATENCY == 1) begin
                        state_d = CH_RESP;
                        enter_o = 1'b1;
                    end else begin
                        state_d = CH_WAIT;
                        cnt_d   = c_WAIT_INIT;
                    end
                end
            end
            CH_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = CH_RESP;
                    enter_o = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            CH_RESP: begin
                if (!hold_w) begin
                    state_d = CH_IDLE;
                end
            end
            default: state_d = CH_IDLE;
        endcase
    end

    // Next-state view: with LATENCY=1 the request enters RESP straight from
    // the inputs, so the parent must see it before it is registered.
    assign req_write_o = (op_d == OP_WRITE);
    assign req_addr_o  = addr_d;
    assign req_data_o  = data_d;

    assign read_ready_o  = (state_q == CH_RESP) && (op_q == OP_READ);
    assign write_ready_o = (state_q == CH_RESP) && (op_q == OP_WRITE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= CH_IDLE;
            op_q    <= OP_READ;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mem_responder
//  Description : Multi-channel fixed-latency memory model. A shared array is
//                served by NUM_CHANNELS independent request FSMs; same-cycle
//                writes are resolved by channel index, reads see the
//                pre-write contents.
//  Ports       : clk, reset (sync, active-low)
//                mem_read_*  / mem_write_*   per-channel request/ack buses
//                load_en/load_addr/load_data backdoor preload
//                peek_addr/peek_data         combinational backdoor read
//                read_count/write_count      saturating completion counters
//  Revision    : 1.0  initial release
// ============================================================================
module mem_responder
    import gpu_mem_pkg::*;
#(
    parameter int ADDR_BITS    = c_DEFAULT_ADDR_BITS,
    parameter int DATA_BITS    = c_DEFAULT_DATA_BITS,
    parameter int NUM_CHANNELS = c_DEFAULT_NUM_CHANNELS,
    parameter int LATENCY      = c_DEFAULT_LATENCY
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_CHANNELS-1:0]           mem_read_valid,
    input  logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_read_address,
    output logic [NUM_CHANNELS-1:0]           mem_read_ready,
    output logic [NUM_CHANNELS*DATA_BITS-1:0] mem_read_data,
    input  logic [NUM_CHANNELS-1:0]           mem_write_valid,
    input  logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_write_address,
    input  logic [NUM_CHANNELS*DATA_BITS-1:0] mem_write_data,
    output logic [NUM_CHANNELS-1:0]           mem_write_ready,
    input  logic                              load_en,
    input  logic [ADDR_BITS-1:0]              load_addr,
    input  logic [DATA_BITS-1:0]              load_data,
    input  logic [ADDR_BITS-1:0]              peek_addr,
    output logic [DATA_BITS-1:0]              peek_data,
    output logic [c_COUNT_BITS-1:0]           read_count,
    output logic [c_COUNT_BITS-1:0]           write_count
);

    localparam int c_DEPTH = 1 << ADDR_BITS;

    logic [DATA_BITS-1:0]              mem_q [c_DEPTH];
    logic [NUM_CHANNELS*DATA_BITS-1:0] rdata_q;
    logic [c_COUNT_BITS-1:0]           rd_count_q, wr_count_q;

    logic [NUM_CHANNELS-1:0]           enter_w, commit_w, req_write_w;
    logic [NUM_CHANNELS*ADDR_BITS-1:0] req_addr_w;
    logic [NUM_CHANNELS*DATA_BITS-1:0] req_data_w;
    logic [c_INC_BITS-1:0]             rd_inc_w, wr_inc_w;

    for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_ch
        mem_resp_channel #(
            .ADDR_BITS (ADDR_BITS),
            .DATA_BITS (DATA_BITS),
            .LATENCY   (LATENCY)
        ) u_chan (
            .clk           (clk),
            .reset         (reset),
            .read_valid_i  (mem_read_valid[ch]),
            .read_addr_i   (mem_read_address[ch*ADDR_BITS +: ADDR_BITS]),
            .write_valid_i (mem_write_valid[ch]),
            .write_addr_i  (mem_write_address[ch*ADDR_BITS +: ADDR_BITS]),
            .write_data_i  (mem_write_data[ch*DATA_BITS +: DATA_BITS]),
            .enter_o       (enter_w[ch]),
            .req_write_o   (req_write_w[ch]),
            .req_addr_o    (req_addr_w[ch*ADDR_BITS +: ADDR_BITS]),
            .req_data_o    (req_data_w[ch*DATA_BITS +: DATA_BITS]),
            .read_ready_o  (mem_read_ready[ch]),
            .write_ready_o (mem_write_ready[ch])
        );
    end

    // A reset on the entry edge abandons the transaction: no access, no count.
    assign commit_w = enter_w & {NUM_CHANNELS{reset}};

    // Array is never reset. Later assignments win, so the load goes first and
    // ascending channel order lets the highest index take a contested address.
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem_q[load_addr] <= load_data;
        end
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            if (commit_w[ch] && req_write_w[ch]) begin
                mem_q[req_addr_w[ch*ADDR_BITS +: ADDR_BITS]] <=
                    req_data_w[ch*DATA_BITS +: DATA_BITS];
            end
        end
    end

    // Reads sample the array before this edge's writes land.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata_q <= '0;
        end else begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                if (commit_w[ch] && !req_write_w[ch]) begin
                    rdata_q[ch*DATA_BITS +: DATA_BITS] <=
                        mem_q[req_addr_w[ch*ADDR_BITS +: ADDR_BITS]];
                end
            end
        end
    end

    always_comb begin
        rd_inc_w = '0;
        wr_inc_w = '0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            if (commit_w[ch]) begin
                if (req_write_w[ch]) begin
                    wr_inc_w = wr_inc_w + 1'b1;
                end else begin
                    rd_inc_w = rd_inc_w + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            rd_count_q <= sat_add(rd_count_q, rd_inc_w);
            wr_count_q <= sat_add(wr_count_q, wr_inc_w);
        end
    end

    assign mem_read_data = rdata_q;
    assign read_count    = rd_count_q;
    assign write_count   = wr_count_q;
    assign peek_data     = mem_q[peek_addr];

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_responder
//  Description : Directed self-checking bench for mem_responder (defaults:
//                8-bit address/data, 4 channels, LATENCY=2).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_responder;

    logic        clk;
    logic        reset;
    logic [3:0]  mem_read_valid;
    logic [31:0] mem_read_address;
    logic [3:0]  mem_read_ready;
    logic [31:0] mem_read_data;
    logic [3:0]  mem_write_valid;
    logic [31:0] mem_write_address;
    logic [31:0] mem_write_data;
    logic [3:0]  mem_write_ready;
    logic        load_en;
    logic [7:0]  load_addr;
    logic [7:0]  load_data;
    logic [7:0]  peek_addr;
    logic [7:0]  peek_data;
    logic [15:0] read_count;
    logic [15:0] write_count;

    int checks = 0;
    int errors = 0;

    localparam int A_BASE = 8'h40;
    localparam int B_BASE = 8'h60;
    localparam int C_BASE = 8'h80;

    mem_responder u_dut (
        .clk               (clk),
        .reset             (reset),
        .mem_read_valid    (mem_read_valid),
        .mem_read_address  (mem_read_address),
        .mem_read_ready    (mem_read_ready),
        .mem_read_data     (mem_read_data),
        .mem_write_valid   (mem_write_valid),
        .mem_write_address (mem_write_address),
        .mem_write_data    (mem_write_data),
        .mem_write_ready   (mem_write_ready),
        .load_en           (load_en),
        .load_addr         (load_addr),
        .load_data         (load_data),
        .peek_addr         (peek_addr),
        .peek_data         (peek_data),
        .read_count        (read_count),
        .write_count       (write_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] addr, input logic [7:0] data);
        load_en   = 1'b1;
        load_addr = addr;
        load_data = data;
        tick();
        load_en   = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        checks++;
        if (mem_read_ready !== 4'b0 || mem_write_ready !== 4'b0) begin
            errors++;
            $display("FAIL reset_ready: rd=%b wr=%b expected 0000/0000", mem_read_ready, mem_write_ready);
        end
        checks++;
        if (mem_read_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata: got %h expected 00000000", mem_read_data);
        end
        checks++;
        if (read_count !== 16'd0 || write_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_counts: rd=%0d wr=%0d expected 0/0", read_count, write_count);
        end
        // Preload while still in reset.
        do_load(8'd3, 8'd4);
        peek_addr = 8'd3;
        #1;
        checks++;
        if (peek_data !== 8'd4) begin
            errors++;
            $display("FAIL load_in_reset: peek[3]=%0d expected 4", peek_data);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_read_latency();
        mem_read_address[7:0] = 8'd3;
        mem_read_valid[0]     = 1'b1;
        tick();
        checks++;
        if (mem_read_ready[0] !== 1'b0) begin
            errors++;
            $display("FAIL read_early: ready=%b after 1 cycle expected 0", mem_read_ready[0]);
        end
        tick();
        checks++;
        if (mem_read_ready[0] !== 1'b1 || mem_read_data[7:0] !== 8'd4) begin
            errors++;
            $display("FAIL read_resp: ready=%b data=%0d expected 1/4", mem_read_ready[0], mem_read_data[7:0]);
        end
        checks++;
        if (read_count !== 16'd1) begin
            errors++;
            $display("FAIL read_count1: got %0d expected 1", read_count);
        end
        mem_read_valid[0] = 1'b0;
        tick();
        checks++;
        if (mem_read_ready[0] !== 1'b0) begin
            errors++;
            $display("FAIL read_drop: ready=%b expected 0", mem_read_ready[0]);
        end
    endtask

    task automatic test_hold();
        mem_read_address[7:0] = 8'd3;
        mem_read_valid[0]     = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (mem_read_ready[0] !== 1'b1 || mem_read_data[7:0] !== 8'd4) begin
                errors++;
                $display("FAIL hold_stable[%0d]: ready=%b data=%0d expected 1/4", i, mem_read_ready[0], mem_read_data[7:0]);
            end
        end
        mem_read_valid[0] = 1'b0;
        tick();
        checks++;
        if (mem_read_ready[0] !== 1'b0) begin
            errors++;
            $display("FAIL hold_drop: ready=%b expected 0", mem_read_ready[0]);
        end
        tick();
        checks++;
        if (read_count !== 16'd2) begin
            errors++;
            $display("FAIL hold_count: got %0d expected 2", read_count);
        end
    endtask

    task automatic test_rw_same_addr();
        do_load(8'd35, 8'd7);
        mem_write_valid[1]       = 1'b1;
        mem_write_address[15:8]  = 8'd35;
        mem_write_data[15:8]     = 8'd20;
        mem_read_valid[2]        = 1'b1;
        mem_read_address[23:16]  = 8'd35;
        tick();
        tick();
        peek_addr = 8'd35;
        #1;
        checks++;
        if (mem_read_ready[2] !== 1'b1 || mem_read_data[23:16] !== 8'd7) begin
            errors++;
            $display("FAIL rw_old_value: ready=%b data=%0d expected 1/7", mem_read_ready[2], mem_read_data[23:16]);
        end
        checks++;
        if (mem_write_ready[1] !== 1'b1 || peek_data !== 8'd20) begin
            errors++;
            $display("FAIL rw_write: wready=%b peek=%0d expected 1/20", mem_write_ready[1], peek_data);
        end
        mem_write_valid[1] = 1'b0;
        mem_read_valid[2]  = 1'b0;
        tick();
        checks++;
        if (mem_read_ready !== 4'b0 || mem_write_ready !== 4'b0 ||
            read_count !== 16'd3 || write_count !== 16'd1) begin
            errors++;
            $display("FAIL rw_after: rd=%b wr=%b rc=%0d wc=%0d expected 0000/0000/3/1",
                     mem_read_ready, mem_write_ready, read_count, write_count);
        end
    endtask

    task automatic test_write_collision();
        apply_reset();
        mem_write_valid[0]       = 1'b1;
        mem_write_address[7:0]   = 8'd10;
        mem_write_data[7:0]      = 8'd1;
        mem_write_valid[3]       = 1'b1;
        mem_write_address[31:24] = 8'd10;
        mem_write_data[31:24]    = 8'd9;
        tick();
        // Backdoor load lands on the same edge as both channel writes.
        load_en   = 1'b1;
        load_addr = 8'd10;
        load_data = 8'd5;
        tick();
        load_en   = 1'b0;
        peek_addr = 8'd10;
        #1;
        checks++;
        if (peek_data !== 8'd9) begin
            errors++;
            $display("FAIL wcollide_data: mem[10]=%0d expected 9", peek_data);
        end
        checks++;
        if (mem_write_ready !== 4'b1001 || write_count !== 16'd2) begin
            errors++;
            $display("FAIL wcollide_ack: wready=%b wc=%0d expected 1001/2", mem_write_ready, write_count);
        end
        mem_write_valid = 4'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        do_load(8'd50, 8'd33);
        mem_write_valid[1]      = 1'b1;
        mem_write_address[15:8] = 8'd50;
        mem_write_data[15:8]    = 8'd77;
        tick();
        reset = 1'b0;
        tick();
        peek_addr = 8'd50;
        #1;
        checks++;
        if (mem_write_ready !== 4'b0 || peek_data !== 8'd33) begin
            errors++;
            $display("FAIL midreset_abandon: wready=%b mem[50]=%0d expected 0000/33", mem_write_ready, peek_data);
        end
        checks++;
        if (read_count !== 16'd0 || write_count !== 16'd0) begin
            errors++;
            $display("FAIL midreset_counts: rc=%0d wc=%0d expected 0/0", read_count, write_count);
        end
        mem_write_valid[1] = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (mem_write_ready !== 4'b0 || peek_data !== 8'd33 || write_count !== 16'd0) begin
            errors++;
            $display("FAIL midreset_after: wready=%b mem[50]=%0d wc=%0d expected 0000/33/0",
                     mem_write_ready, peek_data, write_count);
        end
    endtask

    // Issue one transaction on every channel in act, wait (bounded) for all
    // acknowledges, capture read data, then release the valids.
    task automatic mm_batch(input logic [3:0] act, input logic is_write,
                            input logic [31:0] addrs, input logic [31:0] wdata,
                            output logic [31:0] rdata);
        logic [3:0] rdy;
        int         n;
        for (int c = 0; c < 4; c++) begin
            if (act[c]) begin
                if (is_write) begin
                    mem_write_valid[c]           = 1'b1;
                    mem_write_address[c*8 +: 8]  = addrs[c*8 +: 8];
                    mem_write_data[c*8 +: 8]     = wdata[c*8 +: 8];
                end else begin
                    mem_read_valid[c]            = 1'b1;
                    mem_read_address[c*8 +: 8]   = addrs[c*8 +: 8];
                end
            end
        end
        n = 0;
        tick();
        rdy = is_write ? mem_write_ready : mem_read_ready;
        while (((rdy & act) != act) && n < 20) begin
            tick();
            n++;
            rdy = is_write ? mem_write_ready : mem_read_ready;
        end
        checks++;
        if ((rdy & act) != act) begin
            errors++;
            $display("FAIL mm_handshake: ready=%b expected %b within 20 cycles", rdy, act);
        end
        rdata           = mem_read_data;
        mem_read_valid  = 4'b0;
        mem_write_valid = 4'b0;
        tick();
    endtask

    task automatic test_matmul();
        int         a_mat [12] = '{0, 1, 2, 3, 4, 5, 6, 7, 10, 4, 6, 6};
        int         exp_c [15] = '{20, 26, 32, 38, 44, 60, 82, 104, 126, 148, 60, 86, 112, 138, 164};
        int         acc [4];
        logic [3:0]  act;
        logic [31:0] addrs, wd, rd_a, rd_b;
        int          e;
        apply_reset();
        for (int i = 0; i < 12; i++) do_load(8'(A_BASE + i), 8'(a_mat[i]));
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 5; j++) do_load(8'(B_BASE + k*5 + j), 8'(k + 1 + j));
        for (int g = 0; g < 4; g++) begin
            act = 4'b0;
            for (int c = 0; c < 4; c++) begin
                acc[c] = 0;
                if (g*4 + c < 15) act[c] = 1'b1;
            end
            for (int k = 0; k < 4; k++) begin
                addrs = '0;
                for (int c = 0; c < 4; c++) begin
                    e = g*4 + c;
                    addrs[c*8 +: 8] = 8'(A_BASE + (e / 5)*4 + k);
                end
                mm_batch(act, 1'b0, addrs, 32'h0, rd_a);
                for (int c = 0; c < 4; c++) begin
                    e = g*4 + c;
                    addrs[c*8 +: 8] = 8'(B_BASE + k*5 + (e % 5));
                end
                mm_batch(act, 1'b0, addrs, 32'h0, rd_b);
                for (int c = 0; c < 4; c++)
                    if (act[c]) acc[c] += int'(rd_a[c*8 +: 8]) * int'(rd_b[c*8 +: 8]);
            end
            wd = '0;
            for (int c = 0; c < 4; c++) begin
                addrs[c*8 +: 8] = 8'(C_BASE + g*4 + c);
                wd[c*8 +: 8]    = 8'(acc[c]);
            end
            mm_batch(act, 1'b1, addrs, wd, rd_a);
        end
        for (int i = 0; i < 15; i++) begin
            peek_addr = 8'(C_BASE + i);
            #1;
            checks++;
            if (peek_data !== 8'(exp_c[i])) begin
                errors++;
                $display("FAIL matmul_c[%0d]: got %0d expected %0d", i, peek_data, exp_c[i]);
            end
        end
        checks++;
        if (read_count !== 16'd120 || write_count !== 16'd15) begin
            errors++;
            $display("FAIL matmul_counts: rc=%0d wc=%0d expected 120/15", read_count, write_count);
        end
    endtask

    initial begin
        reset             = 1'b0;
        mem_read_valid    = 4'b0;
        mem_read_address  = 32'h0;
        mem_write_valid   = 4'b0;
        mem_write_address = 32'h0;
        mem_write_data    = 32'h0;
        load_en           = 1'b0;
        load_addr         = 8'h0;
        load_data         = 8'h0;
        peek_addr         = 8'h0;

        test_reset();
        test_read_latency();
        test_hold();
        test_rw_same_addr();
        test_write_collision();
        test_reset_mid();
        test_matmul();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter ADDR_BITS, 8, address width.
REQ-002 SHALL have parameter DATA_BITS, 8, data word width.
REQ-003 SHALL have parameter NUM_CHANNELS, 4, independent request channels.
REQ-004 SHALL have parameter LATENCY, 2, cycles from accepted valid to ready; legal range 1..15.
REQ-005 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-007 SHALL have port mem_read_valid  input  NUM_CHANNELS  per-channel read request.
REQ-008 SHALL have port mem_read_address  input  NUM_CHANNELS x ADDR_BITS  read address.
REQ-009 SHALL have port mem_read_ready  output  NUM_CHANNELS  read data valid and acknowledge.
REQ-010 SHALL have port mem_read_data  output  NUM_CHANNELS x DATA_BITS  read data.
REQ-011 SHALL have port mem_write_valid  input  NUM_CHANNELS  per-channel write request.
REQ-012 SHALL have port mem_write_address  input  NUM_CHANNELS x ADDR_BITS  write address.
REQ-013 SHALL have port mem_write_data  input  NUM_CHANNELS x DATA_BITS  write data.
REQ-014 SHALL have port mem_write_ready  output  NUM_CHANNELS  write acknowledge.
REQ-015 SHALL have port load_en, load_addr, load_data  inputs  1 / ADDR_BITS / DATA_BITS  backdoor preload write.
REQ-016 SHALL have port peek_addr  input  ADDR_BITS; peek_data  output  DATA_BITS  combinational backdoor read.
REQ-017 SHALL have port read_count, write_count  outputs  16 each  completed transaction counters.

Function
REQ-018 SHALL hold a 2^ADDR_BITS x DATA_BITS array shared by all channels.
REQ-019 SHALL run one FSM per channel: IDLE, WAIT, RESP.
REQ-020 IDLE: read_valid high -> latch address, op=read; else write_valid high -> latch address+data, op=write; read wins if both high.
REQ-021 IDLE exit: to RESP when LATENCY=1, else to WAIT with counter=LATENCY-2.
REQ-022 WAIT: decrement counter; at 0 go to RESP; valid inputs ignored while in WAIT.
REQ-023 On entry to RESP: read -> mem_read_data<=mem[addr], mem_read_ready<=1; write -> mem[addr]<=data, mem_write_ready<=1; the ready edge is exactly LATENCY cycles after the valid was sampled in IDLE.
REQ-024 RESP: hold ready and data stable while the op's valid stays high; when it is low, drop ready next cycle and return to IDLE; the earliest new accept is the cycle after that.
REQ-025 Same-cycle reads and writes to the same address: reads return the pre-write value.
REQ-026 Same-cycle writes to the same address: the highest channel index wins; channel writes override load_en.
REQ-027 read_count/write_count SHALL increment once per RESP entry of the matching op, summed across channels, saturating at 16'hFFFF.
REQ-028 peek_data SHALL equal mem[peek_addr] combinationally, reflecting writes from prior edges only.

Reset
REQ-029 When reset is low at an edge: every FSM goes to IDLE; all ready outputs are 0; mem_read_data is 0; counters are 0.
REQ-030 Array contents SHALL NOT be reset, and load_en SHALL act while reset is low.
REQ-031 A reset mid-transaction SHALL abandon it: no array write unless RESP was already entered, and no count.

Structure
REQ-032 A shared package gpu_mem_pkg SHALL hold the channel state enum, the op enum, and default width constants.
REQ-033 Per-channel FSM and latency counter SHALL live in sub-module mem_resp_channel, instantiated NUM_CHANNELS times; the array, write arbitration and counters stay in mem_responder.

Verification
REQ-034 Preload addr 3=8'd4 via load_en; ch0 read addr 3, LATENCY=2 -> ready high 2 cycles after valid, data 8'd4, count=1.
REQ-035 ch1 writes 8'd20 to addr 35 while ch2 reads addr 35 in the same cycle -> read returns old value; peek 35=8'd20 afterwards.
REQ-036 ch0 and ch3 write 8'd1 and 8'd9 to addr 10 in the same cycle -> mem[10]=8'd9, write_count=2.
REQ-037 Hold valid 5 cycles after ready -> ready and data stay stable; drop valid -> ready low next cycle, no second count.
REQ-038 Assert reset low during WAIT of a write -> ready stays 0, array unchanged, counters 0.
REQ-039 Run 15 concurrent 3x4 * 4x5 matmul-style read/write sequences on 4 channels -> C region equals 20,26,32,38,44,60,82,104,126,148,60,86,112,138,164.
